control_unit: RTL
=================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter: INSTRET_W, 32, width of retired-instruction counter.
REQ-002 SHALL have port: CLK  in  1  rising-edge clock.
REQ-003 SHALL have port: RST  in  1  reset; asynchronous, active-low.
REQ-004 SHALL have port: opcode  in  7  IR[6:0].
REQ-005 SHALL have port: funct3  in  3  IR[14:12].
REQ-006 SHALL have port: funct7  in  7  IR[31:25].
REQ-007 SHALL have port: EQ, LT_SN, LT_UN  in  1 each  ULA compare flags.
REQ-008 SHALL have port: sub  out  1  ULA subtract.
REQ-009 SHALL have port: WE_RF  out  1  regfile write enable.
REQ-010 SHALL have port: WE_MEM  out  1  data memory write enable.
REQ-011 SHALL have port: RF_din_sel  out  1  1 = ULA result, 0 = DM_out to regfile.
REQ-012 SHALL have port: ULA_din2_sel  out  1  1 = extended immediate, 0 = rs2.
REQ-013 SHALL have port: load_pc, pc_next_sel, reset_pc  out  1 each  PC load, 1 = PC+imm / 0 = PC+4, PC clear.
REQ-014 SHALL have port: load_ir  out  1  IR load enable.
REQ-015 SHALL have port: halt  out  1  illegal instruction trapped.
REQ-016 SHALL have port: instret  out  INSTRET_W  retired-instruction count.

Function
REQ-017 SHALL implement FSM states S_RESET, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT; all outputs SHALL be 0 unless stated.
REQ-018 S_RESET: reset_pc=1 for exactly one cycle, then S_FETCH.
REQ-019 S_FETCH: load_ir=1, then S_DECODE.
REQ-020 S_DECODE: classify and register class (R, I-ALU, LOAD, STORE, BRANCH); legal -> S_EXEC, illegal -> S_HALT.
REQ-021 Legal set: R 0110011 f3=000 f7 in {0000000, 0100000}; I-ALU 0010011 f3=000; LOAD 0000011 f3=011; STORE 0100011 f3=011; BRANCH 1100011 f3 in {000,001,100,101,110,111}; all else illegal.
REQ-022 S_EXEC..S_WB SHALL use the registered class; funct3/funct7 SHALL be read live (IR stable outside S_FETCH).
REQ-023 ULA_din2_sel=1 in S_EXEC/S_MEM/S_WB for I-ALU, LOAD, STORE; sub=1 in S_EXEC/S_WB for R with f7=0100000 and in S_EXEC for BRANCH.
REQ-024 S_EXEC: R/I-ALU -> S_WB; LOAD/STORE -> S_MEM; BRANCH: load_pc=1, pc_next_sel=taken, -> S_FETCH.
REQ-025 taken: f3 000 EQ, 001 !EQ, 100 LT_SN, 101 !LT_SN, 110 LT_UN, 111 !LT_UN (Mealy, same cycle).
REQ-026 S_MEM: STORE: WE_MEM=1, load_pc=1, -> S_FETCH; LOAD -> S_WB.
REQ-027 S_WB: WE_RF=1, load_pc=1, RF_din_sel=1 for R/I-ALU, 0 for LOAD, -> S_FETCH.
REQ-028 Latency (fetch to retire): BRANCH 3, R/I-ALU/STORE 4, LOAD 5 cycles.
REQ-029 S_HALT: halt=1, all enables 0, no exit except RST.
REQ-030 instret SHALL increment on every rising edge where load_pc=1, wrapping 2^INSTRET_W-1 -> 0; illegal instructions not counted.
REQ-031 WE_RF, WE_MEM and load_pc SHALL never be asserted in the same cycle as reset_pc or load_ir.

Reset
REQ-032 RST low in any state SHALL immediately force S_RESET, all outputs 0, instret 0, class register cleared.
REQ-033 reset_pc SHALL assert in the first cycle after RST deasserts.
REQ-034 A reset during S_MEM/S_WB SHALL suppress the pending write.

Structure
REQ-035 Opcodes, state encoding and class encoding SHALL live in shared package riscv_pkg.
REQ-036 Combinational legality/class logic SHALL be sub-module instr_decoder; FSM, branch logic, instret in control_unit.

Verification
REQ-037 Release RST -> reset_pc=1 cycle 1, load_ir=1 cycle 2, instret=0.
REQ-038 add (0110011/000/0000000) -> WE_RF=1, RF_din_sel=1, sub=0 in cycle 4; f7=0100000 -> sub=1 in cycles 3-4; instret=1.
REQ-039 ld (0000011/011) -> WE_RF=1, RF_din_sel=0, ULA_din2_sel=1 in cycle 5; sd (0100011/011) -> WE_MEM=1 in cycle 4 only.
REQ-040 beq EQ=1 -> load_pc=1, pc_next_sel=1 cycle 3; EQ=0 -> pc_next_sel=0; bgeu LT_UN=1 -> not taken.
REQ-041 opcode 1111111 -> halt=1 from cycle 3, held 10 cycles, no enables; RST pulse mid-S_WB -> no WE_RF, restart at S_RESET.
REQ-042 INSTRET_W=4, 16 addi -> instret returns to 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared opcodes, FSM state encoding and instruction class encoding
// for the multicycle RISC-V control unit.
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_D   = 3'b011;

    typedef enum logic [2:0] {
        S_RESET,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_e;

    typedef enum logic [2:0] {
        CL_NONE,
        CL_R,
        CL_I,
        CL_LOAD,
        CL_STORE,
        CL_BRANCH
    } class_e;

endpackage

// File: rtl/instr_decoder.sv
// Combinational legality check and class extraction for the
// supported RV64 subset.
module instr_decoder
    import riscv_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic       legal,
    output class_e     cls
);

    logic w_r;
    logic w_i;
    logic w_ld;
    logic w_st;
    logic w_br;

    assign w_r  = (opcode == OP_R) && (funct3 == F3_ADD)
               && ((funct7 == F7_BASE) || (funct7 == F7_ALT));
    assign w_i  = (opcode == OP_I_ALU) && (funct3 == F3_ADD);
    assign w_ld = (opcode == OP_LOAD) && (funct3 == F3_D);
    assign w_st = (opcode == OP_STORE) && (funct3 == F3_D);
    // funct3 010 and 011 are not branch encodings
    assign w_br = (opcode == OP_BRANCH) && (funct3[2:1] != 2'b01);

    always_comb begin
        legal = 1'b1;
        cls   = CL_NONE;
        unique case (1'b1)
            w_r:  cls = CL_R;
            w_i:  cls = CL_I;
            w_ld: cls = CL_LOAD;
            w_st: cls = CL_STORE;
            w_br: cls = CL_BRANCH;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multicycle control FSM: fetch/decode/exec/mem/wb sequencing,
// branch resolution and retired-instruction counter.
module control_unit
    import riscv_pkg::*;
#(
    parameter int INSTRET_W = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    input  logic                 EQ,
    input  logic                 LT_SN,
    input  logic                 LT_UN,
    output logic                 sub,
    output logic                 WE_RF,
    output logic                 WE_MEM,
    output logic                 RF_din_sel,
    output logic                 ULA_din2_sel,
    output logic                 load_pc,
    output logic                 pc_next_sel,
    output logic                 reset_pc,
    output logic                 load_ir,
    output logic                 halt,
    output logic [INSTRET_W-1:0] instret
);

    state_e r_state;
    class_e r_class;
    logic   w_legal;
    class_e w_class;
    logic   w_taken;
    logic   w_alt;
    logic   w_imm;
    logic   w_alu;

    instr_decoder u_dec (
        .opcode (opcode),
        .funct3 (funct3),
        .funct7 (funct7),
        .legal  (w_legal),
        .cls    (w_class)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_RESET;
            r_class <= CL_NONE;
        end else begin
            unique case (r_state)
                S_RESET:  r_state <= S_FETCH;
                S_FETCH:  r_state <= S_DECODE;
                S_DECODE: begin
                    r_class <= w_class;
                    r_state <= w_legal ? S_EXEC : S_HALT;
                end
                S_EXEC: begin
                    unique case (r_class)
                        CL_LOAD, CL_STORE: r_state <= S_MEM;
                        CL_BRANCH:         r_state <= S_FETCH;
                        default:           r_state <= S_WB;
                    endcase
                end
                S_MEM:
                    r_state <= (r_class == CL_STORE) ? S_FETCH : S_WB;
                S_WB:     r_state <= S_FETCH;
                default:  r_state <= S_HALT;
            endcase
        end
    end

    always_comb begin
        w_taken = 1'b0;
        unique case (funct3)
            3'b000:  w_taken = EQ;
            3'b001:  w_taken = !EQ;
            3'b100:  w_taken = LT_SN;
            3'b101:  w_taken = !LT_SN;
            3'b110:  w_taken = LT_UN;
            3'b111:  w_taken = !LT_UN;
            default: w_taken = 1'b0;
        endcase
    end

    assign w_alt = (r_class == CL_R) && (funct7 == F7_ALT);
    assign w_alu = (r_class == CL_R) || (r_class == CL_I);
    assign w_imm = (r_class == CL_I) || (r_class == CL_LOAD)
                || (r_class == CL_STORE);

    always_comb begin
        sub          = 1'b0;
        WE_RF        = 1'b0;
        WE_MEM       = 1'b0;
        RF_din_sel   = 1'b0;
        ULA_din2_sel = 1'b0;
        load_pc      = 1'b0;
        pc_next_sel  = 1'b0;
        reset_pc     = 1'b0;
        load_ir      = 1'b0;
        halt         = 1'b0;
        unique case (r_state)
            // gated so that outputs stay low while RST is held
            S_RESET: reset_pc = RST;
            S_FETCH: load_ir  = 1'b1;
            S_EXEC: begin
                ULA_din2_sel = w_imm;
                if (r_class == CL_BRANCH) begin
                    sub         = 1'b1;
                    load_pc     = 1'b1;
                    pc_next_sel = w_taken;
                end else begin
                    sub = w_alt;
                end
            end
            S_MEM: begin
                ULA_din2_sel = w_imm;
                if (r_class == CL_STORE) begin
                    WE_MEM  = 1'b1;
                    load_pc = 1'b1;
                end
            end
            S_WB: begin
                ULA_din2_sel = w_imm;
                sub          = w_alt;
                WE_RF        = 1'b1;
                load_pc      = 1'b1;
                RF_din_sel   = w_alu;
            end
            S_HALT:  halt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            instret <= '0;
        end else if (load_pc) begin
            instret <= instret + 1'b1;
        end
    end

endmodule
